// File: rtl/cpu_step_controller_if.sv
// Control/status bundle between the step controller and the CPU datapath/front panel.
interface cpu_step_controller_if #(
    parameter int DIV_WIDTH = 24
);
    logic                 step_key;
    logic                 run_sw;
    logic [DIV_WIDTH-1:0] div_sel;
    logic                 bp_en;
    logic [7:0]           bp_addr;
    logic [7:0]           pc;
    logic                 cpu_en;
    logic [1:0]           state;
    logic                 halted;
    logic [15:0]          step_count;

    modport master (
        output step_key, run_sw, div_sel, bp_en, bp_addr, pc,
        input  cpu_en, state, halted, step_count
    );

    modport slave (
        input  step_key, run_sw, div_sel, bp_en, bp_addr, pc,
        output cpu_en, state, halted, step_count
    );
endinterface

// File: rtl/cpu_step_controller.sv
// Single-step / free-run clock-enable generator for a small CPU, with debounced step key.
// Define STEPCTL_BREAKPOINT_EN to build the PC breakpoint, armed flag and HALT state.
module cpu_step_controller #(
    parameter int DEB_CYCLES = 16,
    parameter int DIV_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_step_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]           sync_reg;
    logic                 deb_level_reg;
    logic [CNT_W-1:0]     deb_cnt_reg;
    logic                 press_reg;

    state_t               state_reg, state_next;
    logic [DIV_WIDTH-1:0] prescaler_reg, prescaler_next;
    logic                 cpu_en_reg, cpu_en_next;
    logic [15:0]          step_count_reg;
    logic                 bp_hit;

    // Key front end: synchronizer, then a level that moves only after a full stable window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg      <= 2'b11;
            deb_level_reg <= 1'b1;
            deb_cnt_reg   <= '0;
            press_reg     <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], bus.step_key};
            press_reg <= 1'b0;
            if (sync_reg[1] != deb_level_reg) begin
                if (deb_cnt_reg == DEB_LAST) begin
                    deb_level_reg <= sync_reg[1];
                    deb_cnt_reg   <= '0;
                    press_reg     <= ~sync_reg[1];
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

`ifdef STEPCTL_BREAKPOINT_EN
    logic       armed_reg;
    logic [7:0] exec_pc;

    // While an enable is already high the datapath advances pc on this edge,
    // so the pulse being decided would execute the following instruction.
    assign exec_pc = bus.pc + {7'd0, cpu_en_reg};
    assign bp_hit  = bus.bp_en & armed_reg & (exec_pc == bus.bp_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_reg <= 1'b1;
        end else if ((state_reg == HALT) && (state_next != HALT)) begin
            armed_reg <= 1'b0;
        end else if (cpu_en_reg) begin
            armed_reg <= 1'b1;
        end
    end

    assign bus.halted = (state_reg == HALT);
`else
    logic unused_bp;
    assign unused_bp  = ^{bus.bp_en, bus.bp_addr, bus.pc};
    assign bp_hit     = 1'b0;
    assign bus.halted = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        prescaler_next = prescaler_reg;
        cpu_en_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Run has priority; a press arriving in the same cycle is dropped.
                if (bus.run_sw) begin
                    state_next     = RUN;
                    prescaler_next = '0;
                end else if (press_reg) begin
                    state_next  = STEP;
                    cpu_en_next = 1'b1;
                end
            end
            STEP: begin
                state_next = IDLE;
            end
            RUN: begin
                if (!bus.run_sw) begin
                    state_next     = IDLE;
                    prescaler_next = '0;
                end else if (prescaler_reg >= bus.div_sel) begin
                    prescaler_next = '0;
                    if (bp_hit) begin
                        state_next = HALT;
                    end else begin
                        cpu_en_next = 1'b1;
                    end
                end else begin
                    prescaler_next = prescaler_reg + 1'b1;
                end
            end
            HALT: begin
                if (press_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            prescaler_reg  <= '0;
            cpu_en_reg     <= 1'b0;
            step_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            prescaler_reg <= prescaler_next;
            cpu_en_reg    <= cpu_en_next;
            if (cpu_en_next) begin
                step_count_reg <= step_count_reg + 16'd1;
            end
        end
    end

    assign bus.cpu_en     = cpu_en_reg;
    assign bus.state      = state_reg;
    assign bus.step_count = step_count_reg;
endmodule

// File: doc/cpu_step_controller.md
CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable clocks required to accept a new key level.
REQ-002 Parameter DIV_WIDTH, default 24: width of prescaler and div_sel.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 step_key  input  1  raw push-button, active-low, asynchronous to clk.
REQ-006 run_sw  input  1  1 = free-run mode, 0 = single-step mode.
REQ-007 div_sel  input  DIV_WIDTH  run-mode period minus one, in clk cycles.
REQ-008 bp_en  input  1  breakpoint enable.
REQ-009 bp_addr  input  8  breakpoint PC address.
REQ-010 pc  input  8  current program counter of the datapath.
REQ-011 cpu_en  output  1  registered one-cycle enable for PC and register-file writes.
REQ-012 state  output  2  FSM state: IDLE=00, STEP=01, RUN=10, HALT=11.
REQ-013 halted  output  1  high while state is HALT.
REQ-014 step_count  output  16  number of cpu_en pulses issued, wraps 0xFFFF->0x0000.

Function
REQ-015 step_key SHALL pass a 2-flop synchronizer before any use.
REQ-016 Debounced level SHALL change only after the synchronized key differs from it for DEB_CYCLES consecutive clocks; any bounce restarts the count.
REQ-017 A press event SHALL be a single-cycle pulse on a debounced 1->0 transition; a release SHALL produce no event.
REQ-018 IDLE: run_sw=1 -> RUN with prescaler cleared; else a press event -> STEP; if both occur in one cycle, run wins and the press is discarded.
REQ-019 STEP: cpu_en=1 for exactly one cycle, step_count increments, next state IDLE unconditionally; the breakpoint is not checked in STEP.
REQ-020 RUN: prescaler increments each cycle; when prescaler >= div_sel, cpu_en pulses one cycle, step_count increments, and prescaler returns to 0, giving a period of div_sel+1 cycles (div_sel=0 -> cpu_en every cycle).
REQ-021 RUN: run_sw=0 -> IDLE, prescaler cleared, and no pulse issued in that cycle.
REQ-022 RUN: press events SHALL be ignored.
REQ-023 Breakpoint hit = bp_en & armed & (pc == bp_addr); a hit in RUN -> HALT in the same cycle the pulse would otherwise issue, and suppresses that pulse.
REQ-024 The armed flag SHALL clear on leaving HALT and re-set after the next cpu_en pulse, so a resume executes the breakpoint instruction once.
REQ-025 HALT: cpu_en=0; a press event -> IDLE; if run_sw is still 1, IDLE -> RUN on the following cycle.
REQ-026 cpu_en SHALL never be high on two consecutive cycles except in RUN with div_sel=0.

Reset
REQ-027 rst SHALL immediately force state=IDLE, cpu_en=0, halted=0, step_count=0, prescaler=0, debounce counter=0, debounced level=1, synchronizer flops=1, armed=1.
REQ-028 rst asserted mid-pulse or mid-run SHALL drop cpu_en in the same cycle without waiting for a clock edge; no pulse SHALL issue on the first clock after rst deasserts.

Configuration
REQ-029 Macro STEPCTL_BREAKPOINT_EN defined: breakpoint logic, armed flag and HALT state exist per REQ-023..REQ-025.
REQ-030 Macro STEPCTL_BREAKPOINT_EN undefined: bp_en, bp_addr and pc are ignored; HALT is unreachable; halted is tied to 0; all other behaviour is unchanged.

Verification (DEB_CYCLES=4)
REQ-031 run_sw=0; step_key low for 10 clks, bouncing twice in the first 3 -> exactly one cpu_en pulse; step_count=1; state sequence IDLE->STEP->IDLE.
REQ-032 run_sw=1, div_sel=3, 20 clks -> cpu_en every 4th cycle, 5 pulses, step_count=5.
REQ-033 Macro defined; run_sw=1, div_sel=0, bp_en=1, bp_addr=0x05, pc incremented on each cpu_en from 0 -> HALT with pc=0x05; halted=1; no further pulses; one press -> one pulse at 0x05, then run resumes and does not re-halt at 0x05.
REQ-034 run_sw=1, div_sel=9, rst asserted at prescaler=5 -> cpu_en, step_count and state read 0/0/IDLE asynchronously; first pulse after release occurs 10 clks after RUN entry.
REQ-035 In IDLE, run_sw rising in the same cycle as a press event -> RUN, no STEP pulse; step_count at 0xFFFF plus one pulse -> 0x0000.
REQ-036 Macro undefined; repeat REQ-033 stimulus -> no HALT, halted=0, pulses continue past pc=0x05.
